bus_arbiter4: RTL and testbench

Four-requester round-robin bus arbiter that produces the registered 2-bit select driving the shared four-way data multiplexer, plus a one-hot grant back to the requesters. Each requester holds its request for as long as it owns the bus. The arbiter serialises ownership, rotates priority for fairness, and keeps the mux select stable for the whole ownership period. It sits directly upstream of the 4:1 mux, whose select input is driven by `sel`.

---
 rtl/bus_arbiter4_if.sv | 25 ++
 rtl/bus_arbiter4.sv | 142 ++++++++++++++
 tb/tb_bus_arbiter4.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter4_if.sv
// Request/grant bundle between the four requesters and bus_arbiter4.
// "master" is the requester side; "slave" is the arbiter side.
interface bus_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output busy,
    output timeout
  );
endinterface

// File: rtl/bus_arbiter4.sv
// Four-requester round-robin arbiter driving the registered 4:1 mux select.
// Optional grant-hold timeout is compiled in with BUS_ARBITER4_TIMEOUT_EN.
module bus_arbiter4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rstn,
  bus_arbiter4_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  if ((MAX_HOLD < 32'sd2) || (MAX_HOLD > 32'sd256)) begin : g_bad_max_hold
    $error("bus_arbiter4: MAX_HOLD must be within 2..256");
  end

  // First requester found scanning ptr, ptr+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + i[1:0];
      if (req[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] gnt_q,   gnt_d;
  logic [1:0] sel_q,   sel_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [1:0] win_s;

  assign win_s = rr_pick(bus.req, ptr_q);

`ifdef BUS_ARBITER4_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             hold_max_s;

  assign hold_max_s = (cnt_q == CNT_W'(MAX_HOLD - 1));
`endif

  // Next-state, grant, select and pointer decisions.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef BUS_ARBITER4_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << win_s;
          sel_d   = win_s;
          ptr_d   = win_s + 2'd1;
`ifdef BUS_ARBITER4_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
        end
      end
      ST_GRANT: begin
        // Only the owner's request matters here; others wait for the turnaround cycle.
        if (!bus.req[sel_q]) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
`ifdef BUS_ARBITER4_TIMEOUT_EN
        end else if (hold_max_s) begin
          state_d   = ST_IDLE;
          gnt_d     = 4'b0000;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_GRANT;
          cnt_d   = cnt_q + CNT_W'(1);
        end
`else
        end else begin
          state_d = ST_GRANT;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef BUS_ARBITER4_TIMEOUT_EN
  // Hold counter and revocation pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = |gnt_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Table-driven, scoreboarded bench for bus_arbiter4 (MAX_HOLD = 4).
module tb_bus_arbiter4;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  bus_arbiter4_if bus_if ();

  bus_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
  } vec_t;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[38];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "/gnt"},     bus_if.gnt,                e.gnt);
      check({tag, "/sel"},     {2'b00, bus_if.sel},       {2'b00, e.sel});
      check({tag, "/busy"},    {3'b000, bus_if.busy},     {3'b000, |e.gnt});
      check({tag, "/timeout"}, {3'b000, bus_if.timeout},  {3'b000, e.to});
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                      input logic to, input string tag);
    exp_t e;
    @(negedge clk);
    bus_if.req = r;
    e.gnt = g;
    e.sel = s;
    e.to  = to;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // single request for 2, release, then rotation checks (ptr=3 -> 0 wins, ptr=1 -> 2 wins)
    tbl[0]  = '{4'b0100, 4'b0100, 2'd2};
    tbl[1]  = '{4'b0100, 4'b0100, 2'd2};
    tbl[2]  = '{4'b0000, 4'b0000, 2'd2};
    tbl[3]  = '{4'b0101, 4'b0001, 2'd0};
    tbl[4]  = '{4'b0100, 4'b0000, 2'd0};
    tbl[5]  = '{4'b0101, 4'b0100, 2'd2};
    tbl[6]  = '{4'b0001, 4'b0000, 2'd2};
    // all four requesting, each owner releases after two cycles: 3,0,1,2,3
    tbl[7]  = '{4'b1111, 4'b1000, 2'd3};
    tbl[8]  = '{4'b1111, 4'b1000, 2'd3};
    tbl[9]  = '{4'b0111, 4'b0000, 2'd3};
    tbl[10] = '{4'b1111, 4'b0001, 2'd0};
    tbl[11] = '{4'b1111, 4'b0001, 2'd0};
    tbl[12] = '{4'b1110, 4'b0000, 2'd0};
    tbl[13] = '{4'b1111, 4'b0010, 2'd1};
    tbl[14] = '{4'b1111, 4'b0010, 2'd1};
    tbl[15] = '{4'b1101, 4'b0000, 2'd1};
    tbl[16] = '{4'b1111, 4'b0100, 2'd2};
    tbl[17] = '{4'b1111, 4'b0100, 2'd2};
    tbl[18] = '{4'b1011, 4'b0000, 2'd2};
    tbl[19] = '{4'b1111, 4'b1000, 2'd3};
    tbl[20] = '{4'b1111, 4'b1000, 2'd3};
    tbl[21] = '{4'b0111, 4'b0000, 2'd3};
    // requester 1 owns while 0 and 3 toggle
    tbl[22] = '{4'b0010, 4'b0010, 2'd1};
    for (int i = 23; i <= 32; i++) begin
      tbl[i] = '{((i % 2) != 0) ? 4'b1011 : 4'b0010, 4'b0010, 2'd1};
    end
    tbl[33] = '{4'b0000, 4'b0000, 2'd1};
    // one-cycle pulse still gets a one-cycle grant; lone previous owner regains bus
    tbl[34] = '{4'b1000, 4'b1000, 2'd3};
    tbl[35] = '{4'b0000, 4'b0000, 2'd3};
    tbl[36] = '{4'b1000, 4'b1000, 2'd3};
    tbl[37] = '{4'b0000, 4'b0000, 2'd3};

    bus_if.req = 4'b0000;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/gnt",     bus_if.gnt,              4'b0000);
    check("reset/sel",     {2'b00, bus_if.sel},     4'b0000);
    check("reset/busy",    {3'b000, bus_if.busy},   4'b0000);
    check("reset/timeout", {3'b000, bus_if.timeout}, 4'b0000);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 38; i++) begin
      step(tbl[i].req, tbl[i].gnt, tbl[i].sel, 1'b0, $sformatf("vec%0d", i));
    end

    // asynchronous reset between edges while requester 3 owns
    step(4'b1000, 4'b1000, 2'd3, 1'b0, "ar_grant");
    #2;
    rstn = 1'b0;
    #1;
    check("ar/gnt",  bus_if.gnt,            4'b0000);
    check("ar/sel",  {2'b00, bus_if.sel},   4'b0000);
    check("ar/busy", {3'b000, bus_if.busy}, 4'b0000);
    bus_if.req = 4'b0000;
    @(negedge clk);
    rstn = 1'b1;
    step(4'b1001, 4'b0001, 2'd0, 1'b0, "ar_regrant");
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "ar_release");

    // requester 0 owns, requester 1 joins and keeps requesting
    step(4'b0001, 4'b0001, 2'd0, 1'b0, "hold_c1");
`ifdef BUS_ARBITER4_TIMEOUT_EN
    step(4'b0011, 4'b0001, 2'd0, 1'b0, "to_c2");
    step(4'b0011, 4'b0001, 2'd0, 1'b0, "to_c3");
    step(4'b0011, 4'b0001, 2'd0, 1'b0, "to_c4");
    step(4'b0011, 4'b0000, 2'd0, 1'b1, "to_revoke");
    step(4'b0011, 4'b0010, 2'd1, 1'b0, "to_next");
    step(4'b0011, 4'b0010, 2'd1, 1'b0, "to_hold");
    step(4'b0001, 4'b0000, 2'd1, 1'b0, "to_release");
`else
    for (int i = 0; i < 105; i++) begin
      step(4'b0011, 4'b0001, 2'd0, 1'b0, $sformatf("nohold%0d", i));
    end
    step(4'b0010, 4'b0000, 2'd0, 1'b0, "nohold_release");
    step(4'b0010, 4'b0010, 2'd1, 1'b0, "nohold_next");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
